// File: rtl/captura_clave.sv
// rtl/captura_clave.sv - keypad PIN collector: two BCD digits, Enter delivery, inactivity timeout
// Optional build macro CAPTURA_CLAVE_AUTO_ENVIO_EN: deliver on the second digit without Enter.
module captura_clave #(
    parameter int TIMEOUT_CICLOS = 1000,
    parameter int ANCHO_TIMEOUT  = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sensor_llegada_vehiculo,
    input  logic       tecla_valida,
    input  logic [3:0] tecla_codigo,
    output logic [7:0] clave_ingresada,
    output logic       clave_lista,
    output logic [1:0] digitos_capturados,
    output logic       error_tiempo
);

    typedef enum logic [3:0] {
        INACTIVO = 4'b0001,
        CAPTURA  = 4'b0010,
        COMPLETA = 4'b0100,
        ENTREGA  = 4'b1000
    } estado_t;

    estado_t                  estado, estado_next;
    logic [7:0]               buffer, buffer_next;
    logic [1:0]               count, count_next;
    logic [ANCHO_TIMEOUT-1:0] timer, timer_next;
    logic [7:0]               clave_next;
    logic                     lista_next, error_next;

    logic es_digito, es_borrar;
    assign es_digito = tecla_valida && (tecla_codigo <= 4'h9);
    assign es_borrar = tecla_valida && (tecla_codigo == 4'hA);
`ifndef CAPTURA_CLAVE_AUTO_ENVIO_EN
    logic es_enter;
    assign es_enter = tecla_valida && (tecla_codigo == 4'hB);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            estado          <= INACTIVO;
            buffer          <= 8'h00;
            count           <= 2'd0;
            timer           <= '0;
            clave_ingresada <= 8'h00;
            clave_lista     <= 1'b0;
            error_tiempo    <= 1'b0;
        end else begin
            estado          <= estado_next;
            buffer          <= buffer_next;
            count           <= count_next;
            timer           <= timer_next;
            clave_ingresada <= clave_next;
            clave_lista     <= lista_next;
            error_tiempo    <= error_next;
        end
    end

    always_comb begin
        estado_next = estado;
        buffer_next = buffer;
        count_next  = count;
        timer_next  = timer;
        clave_next  = clave_ingresada;
        lista_next  = 1'b0;
        error_next  = 1'b0;
        case (estado)
            INACTIVO: begin
                timer_next = '0;
                if (sensor_llegada_vehiculo)
                    estado_next = CAPTURA;
            end
            CAPTURA, COMPLETA: begin
                // Sensor drop outranks any key; a key outranks the timeout.
                if (!sensor_llegada_vehiculo) begin
                    estado_next = INACTIVO;
                    buffer_next = 8'h00;
                    count_next  = 2'd0;
                    timer_next  = '0;
                end else if (tecla_valida) begin
                    timer_next = '0;
                    if (es_borrar) begin
                        buffer_next = 8'h00;
                        count_next  = 2'd0;
                        estado_next = CAPTURA;
                    end else if (es_digito && estado == CAPTURA) begin
                        buffer_next = {buffer[3:0], tecla_codigo};
                        count_next  = count + 2'd1;
                        if (count == 2'd1) begin
`ifdef CAPTURA_CLAVE_AUTO_ENVIO_EN
                            estado_next = ENTREGA;
`else
                            estado_next = COMPLETA;
`endif
                        end
                    end
`ifndef CAPTURA_CLAVE_AUTO_ENVIO_EN
                    else if (es_enter && estado == COMPLETA) begin
                        estado_next = ENTREGA;
                    end
`endif
                end else if (count != 2'd0) begin
                    if (timer == ANCHO_TIMEOUT'(TIMEOUT_CICLOS - 1)) begin
                        buffer_next = 8'h00;
                        count_next  = 2'd0;
                        timer_next  = '0;
                        error_next  = 1'b1;
                        estado_next = CAPTURA;
                    end else begin
                        timer_next = timer + ANCHO_TIMEOUT'(1);
                    end
                end else begin
                    timer_next = '0;
                end
            end
            ENTREGA: begin
                clave_next  = buffer;
                lista_next  = 1'b1;
                buffer_next = 8'h00;
                count_next  = 2'd0;
                timer_next  = '0;
                estado_next = sensor_llegada_vehiculo ? CAPTURA : INACTIVO;
            end
            default: begin
                estado_next = INACTIVO;
                buffer_next = 8'h00;
                count_next  = 2'd0;
                timer_next  = '0;
            end
        endcase
    end

    assign digitos_capturados = count;

endmodule

// File: tb/tb_captura_clave.sv
// tb/tb_captura_clave.sv - directed vector bench for captura_clave
module tb_captura_clave;

    localparam int T_CICLOS = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       sensor = 1'b0;
    logic       valida = 1'b0;
    logic [3:0] codigo = 4'h0;
    logic [7:0] clave_ingresada;
    logic       clave_lista;
    logic [1:0] digitos_capturados;
    logic       error_tiempo;

    int checks = 0;
    int errors = 0;

    captura_clave #(.TIMEOUT_CICLOS(T_CICLOS), .ANCHO_TIMEOUT(5)) dut (
        .clock                   (clock),
        .reset                   (reset),
        .sensor_llegada_vehiculo (sensor),
        .tecla_valida            (valida),
        .tecla_codigo            (codigo),
        .clave_ingresada         (clave_ingresada),
        .clave_lista             (clave_lista),
        .digitos_capturados      (digitos_capturados),
        .error_tiempo            (error_tiempo)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       s;
        logic       v;
        logic [3:0] c;
        logic [7:0] clave;
        logic       lista;
        logic [1:0] dig;
        logic       err;
    } vec_t;

    vec_t tabla[$];

    task automatic chk(input string nombre, input int actual, input int esperado);
        checks++;
        if (actual !== esperado) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nombre, $time, actual, esperado);
        end
    endtask

    task automatic step(input logic s, input logic v, input logic [3:0] c);
        sensor = s;
        valida = v;
        codigo = c;
        @(posedge clock);
        #1;
        valida = 1'b0;
    endtask

    task automatic add(input logic s, input logic v, input logic [3:0] c,
                       input logic [7:0] clave, input logic lista,
                       input logic [1:0] dig, input logic err);
        vec_t x;
        x.s = s; x.v = v; x.c = c;
        x.clave = clave; x.lista = lista; x.dig = dig; x.err = err;
        tabla.push_back(x);
    endtask

    task automatic chk_all(input string tag, input logic [7:0] clave, input logic lista,
                           input logic [1:0] dig, input logic err);
        chk({tag, " clave"}, clave_ingresada, clave);
        chk({tag, " lista"}, clave_lista, lista);
        chk({tag, " digitos"}, digitos_capturados, dig);
        chk({tag, " error"}, error_tiempo, err);
    endtask

    initial begin
        int n_err;
        reset = 1'b1;
        step(1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b0, 4'h0);
        chk_all("reset", 8'h00, 1'b0, 2'd0, 1'b0);
        reset = 1'b0;

`ifndef CAPTURA_CLAVE_AUTO_ENVIO_EN
        // sensor, valid, code -> clave, lista, digitos, error (after the edge)
        add(0, 1, 4'h4, 8'h00, 0, 0, 0);
        add(0, 1, 4'hB, 8'h00, 0, 0, 0);
        add(1, 0, 4'h0, 8'h00, 0, 0, 0);
        add(1, 1, 4'h4, 8'h00, 0, 1, 0);
        add(1, 1, 4'h7, 8'h00, 0, 2, 0);
        add(1, 1, 4'hB, 8'h00, 0, 2, 0);
        add(1, 0, 4'h0, 8'h47, 1, 0, 0);
        add(1, 0, 4'h0, 8'h47, 0, 0, 0);
        add(1, 1, 4'h4, 8'h47, 0, 1, 0);
        add(1, 1, 4'hA, 8'h47, 0, 0, 0);
        add(1, 1, 4'h2, 8'h47, 0, 1, 0);
        add(1, 1, 4'h5, 8'h47, 0, 2, 0);
        add(1, 1, 4'h9, 8'h47, 0, 2, 0);
        add(1, 1, 4'hE, 8'h47, 0, 2, 0);
        add(1, 1, 4'hB, 8'h47, 0, 2, 0);
        add(1, 0, 4'h0, 8'h25, 1, 0, 0);
        add(1, 0, 4'h0, 8'h25, 0, 0, 0);
        add(1, 1, 4'h6, 8'h25, 0, 1, 0);
        add(1, 1, 4'hB, 8'h25, 0, 1, 0);
        add(1, 1, 4'hA, 8'h25, 0, 0, 0);
        add(1, 1, 4'h1, 8'h25, 0, 1, 0);
        add(1, 1, 4'h2, 8'h25, 0, 2, 0);
        add(0, 1, 4'hB, 8'h25, 0, 0, 0);
        add(0, 0, 4'h0, 8'h25, 0, 0, 0);
        add(0, 1, 4'h3, 8'h25, 0, 0, 0);
        add(1, 0, 4'h0, 8'h25, 0, 0, 0);
        add(1, 1, 4'h8, 8'h25, 0, 1, 0);
        add(1, 1, 4'h0, 8'h25, 0, 2, 0);
        add(1, 1, 4'hB, 8'h25, 0, 2, 0);
        add(0, 0, 4'h0, 8'h80, 1, 0, 0);
        add(1, 1, 4'h5, 8'h80, 0, 0, 0);
        add(1, 1, 4'h5, 8'h80, 0, 1, 0);
        add(1, 1, 4'hA, 8'h80, 0, 0, 0);

        for (int i = 0; i < tabla.size(); i++) begin
            step(tabla[i].s, tabla[i].v, tabla[i].c);
            chk_all($sformatf("vec%0d", i), tabla[i].clave, tabla[i].lista,
                    tabla[i].dig, tabla[i].err);
        end

        // Timeout of a one-digit partial entry
        step(1, 1, 4'h3);
        chk("to_key digitos", digitos_capturados, 1);
        n_err = 0;
        for (int i = 1; i < T_CICLOS; i++) begin
            step(1, 0, 4'h0);
            if (error_tiempo) n_err++;
        end
        chk("to_early error", n_err, 0);
        step(1, 0, 4'h0);
        chk_all("to_expire", 8'h80, 1'b0, 2'd0, 1'b1);
        step(1, 0, 4'h0);
        chk("to_pulse error", error_tiempo, 0);

        // Key arriving on the expiry edge wins; then a full buffer times out
        step(1, 1, 4'h3);
        for (int i = 1; i < T_CICLOS; i++) step(1, 0, 4'h0);
        step(1, 1, 4'h4);
        chk_all("to_key_wins", 8'h80, 1'b0, 2'd2, 1'b0);
        n_err = 0;
        for (int i = 1; i < T_CICLOS; i++) begin
            step(1, 0, 4'h0);
            if (error_tiempo || clave_lista) n_err++;
        end
        chk("to2_early strobes", n_err, 0);
        step(1, 0, 4'h0);
        chk_all("to2_expire", 8'h80, 1'b0, 2'd0, 1'b1);

        // Reset mid-entry and reset cancelling a pending delivery
        step(1, 1, 4'h1);
        chk("mid digitos", digitos_capturados, 1);
        reset = 1'b1;
        step(1, 0, 4'h0);
        chk_all("mid_reset", 8'h00, 1'b0, 2'd0, 1'b0);
        reset = 1'b0;
        step(1, 0, 4'h0);
        step(1, 1, 4'h5);
        step(1, 1, 4'h6);
        step(1, 1, 4'hB);
        reset = 1'b1;
        step(1, 0, 4'h0);
        chk_all("cancel_reset", 8'h00, 1'b0, 2'd0, 1'b0);
        reset = 1'b0;
        step(1, 0, 4'h0);
        chk("cancel_after lista", clave_lista, 0);
`else
        step(1, 0, 4'h0);
        step(1, 1, 4'h9);
        chk("auto d1 digitos", digitos_capturados, 1);
        step(1, 1, 4'h1);
        chk_all("auto d2", 8'h00, 1'b0, 2'd2, 1'b0);
        step(1, 0, 4'h0);
        chk_all("auto deliver", 8'h91, 1'b1, 2'd0, 1'b0);
        step(1, 0, 4'h0);
        chk("auto pulse lista", clave_lista, 0);
        step(1, 1, 4'h3);
        step(1, 1, 4'hB);
        chk("auto enter ignored", digitos_capturados, 1);
        reset = 1'b1;
        step(1, 0, 4'h0);
        chk_all("auto reset", 8'h00, 1'b0, 2'd0, 1'b0);
        reset = 1'b0;
        step(1, 0, 4'h0);
        step(1, 1, 4'h5);
        step(1, 1, 4'h0);
        step(1, 0, 4'h0);
        chk_all("auto deliver2", 8'h50, 1'b1, 2'd0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
